// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches words over req/ack, holds them in an instruction register for the decoder.
// Latency: instruction visible one cycle after the ack; zero-wait-state memory gives one instruction per 2 cycles.
// Backpressure: the held instruction is kept until the decoder raises pc_enable_in; memory stalls by withholding ack.
//
// Ports:
//   clk_in, rst_in          single rising-edge clock, asynchronous active-high reset
//   pc_enable_in            decoder request to advance to the next instruction (honoured only in HOLD)
//   imem_req_out/_addr_out  registered fetch request and its word address (address always equals pc_out)
//   imem_ack_in/_data_in    memory ack with same-cycle data; ignored unless a request is outstanding
//   instr_out, instr_valid_out, pc_out   instruction register, its valid flag, and its address
//   opcode_out, func_out    decoder fields; bubble values while no valid instruction is held
//   fetch_error_out         sticky ack-timeout flag
//
// Optional build macro FETCH_TIMEOUT_EN: adds an ack watchdog of TIMEOUT_CYCLES request cycles that
// parks the stage in ERROR until reset. Without it REQ waits forever and fetch_error_out is tied low.

module instr_fetch #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter int                    PC_STEP        = 4,
    parameter logic [5:0]            BUBBLE_OPCODE  = 6'b111111,
    parameter int                    TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  pc_enable_in,
    output logic                  imem_req_out,
    output logic [ADDR_WIDTH-1:0] imem_addr_out,
    input  logic                  imem_ack_in,
    input  logic [31:0]           imem_data_in,
    output logic [31:0]           instr_out,
    output logic [5:0]            opcode_out,
    output logic [5:0]            func_out,
    output logic                  instr_valid_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  fetch_error_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
    logic                  instr_valid;
    logic                  req;
    logic                  fetch_error;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Counts REQ cycles that ended without an ack; cleared whenever REQ is entered.
    logic [CNT_W-1:0] wait_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            req         <= 1'b0;
            fetch_error <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Any ack seen here has no request behind it and is dropped.
                    req   <= 1'b1;
                    state <= REQ;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end

                REQ: begin
                    // pc_enable_in is deliberately not looked at while a fetch is pending.
                    if (imem_ack_in) begin
                        instr       <= imem_data_in;
                        instr_valid <= 1'b1;
                        req         <= 1'b0;
                        state       <= HOLD;
`ifdef FETCH_TIMEOUT_EN
                    end else if (wait_cnt == CNT_LAST) begin
                        // This edge closes the TIMEOUT_CYCLES-th unanswered request cycle.
                        fetch_error <= 1'b1;
                        req         <= 1'b0;
                        state       <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end

                HOLD: begin
                    if (pc_enable_in) begin
                        // Wraps modulo 2^ADDR_WIDTH by construction of the adder width.
                        pc          <= pc + STEP;
                        instr_valid <= 1'b0;
                        req         <= 1'b1;
                        state       <= REQ;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end

                ERROR: begin
                    // Terminal until reset; outputs already show a bubble and no request.
                    req         <= 1'b0;
                    instr_valid <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_out    = req;
    assign imem_addr_out   = pc;
    assign pc_out          = pc;
    assign instr_out       = instr;
    assign instr_valid_out = instr_valid;

`ifdef FETCH_TIMEOUT_EN
    assign fetch_error_out = fetch_error;
`else
    assign fetch_error_out = 1'b0;
`endif

    // Invalid slots steer the decoder to its default (no-write) branch.
    always_comb begin
        opcode_out = BUBBLE_OPCODE;
        func_out   = 6'b000000;
        if (instr_valid) begin
            opcode_out = instr[31:26];
            func_out   = instr[5:0];
        end
    end

`ifndef FETCH_TIMEOUT_EN
    logic unused_error_state;
    assign unused_error_state = fetch_error;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table for the fetch/hold flow plus
// hand-written sequences for PC wrap, reset during a pending fetch, and the ack watchdog.
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals (RESET_PC = 0)
    logic        rst, en, ack;
    logic [31:0] data;
    logic        req, valid, err;
    logic [31:0] addr, instr, pc;
    logic [5:0]  op, fn;

    // Wrap instance signals (RESET_PC = FFFF_FFFC)
    logic        rst2, en2, ack2;
    logic [31:0] data2;
    logic        req2, valid2, err2;
    logic [31:0] addr2, instr2, pc2;
    logic [5:0]  op2, fn2;

    instr_fetch dut (
        .clk_in(clk), .rst_in(rst), .pc_enable_in(en),
        .imem_req_out(req), .imem_addr_out(addr),
        .imem_ack_in(ack), .imem_data_in(data),
        .instr_out(instr), .opcode_out(op), .func_out(fn),
        .instr_valid_out(valid), .pc_out(pc), .fetch_error_out(err)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk_in(clk), .rst_in(rst2), .pc_enable_in(en2),
        .imem_req_out(req2), .imem_addr_out(addr2),
        .imem_ack_in(ack2), .imem_data_in(data2),
        .instr_out(instr2), .opcode_out(op2), .func_out(fn2),
        .instr_valid_out(valid2), .pc_out(pc2), .fetch_error_out(err2)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        en;
        logic        ack;
        logic [31:0] data;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [5:0]  op;
        logic [5:0]  fn;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    function automatic vec_t mk(input logic e, input logic a, input logic [31:0] d,
                                input logic r, input logic [31:0] ad, input logic v,
                                input logic [31:0] ins, input logic [5:0] o, input logic [5:0] f);
        vec_t t;
        t.en = e; t.ack = a; t.data = d; t.req = r; t.addr = ad;
        t.valid = v; t.instr = ins; t.op = o; t.fn = f;
        return t;
    endfunction

    task automatic chk_main(input string tag, input logic r, input logic [31:0] ad, input logic v,
                            input logic [31:0] ins, input logic [5:0] o, input logic [5:0] f);
        chk({tag, " req"},    32'(req),   32'(r));
        chk({tag, " addr"},   addr,       ad);
        chk({tag, " pc"},     pc,         ad);
        chk({tag, " valid"},  32'(valid), 32'(v));
        chk({tag, " instr"},  instr,      ins);
        chk({tag, " opcode"}, 32'(op),    32'(o));
        chk({tag, " func"},   32'(fn),    32'(f));
        chk({tag, " err"},    32'(err),   32'd0);
    endtask

    initial begin
        // Ack held high with continuous advance: addr 0,4,8,C with valid every 2nd cycle.
        vt[0]  = mk(1, 1, 32'hA0A0_A0A0, 1, 32'h0,  0, 32'h0,         6'h3F, 6'h00);
        vt[1]  = mk(1, 1, 32'h8C00_0011, 0, 32'h0,  1, 32'h8C00_0011, 6'h23, 6'h11);
        vt[2]  = mk(1, 1, 32'h5555_5555, 1, 32'h4,  0, 32'h8C00_0011, 6'h3F, 6'h00);
        vt[3]  = mk(1, 1, 32'h2000_002A, 0, 32'h4,  1, 32'h2000_002A, 6'h08, 6'h2A);
        vt[4]  = mk(1, 1, 32'h6666_6666, 1, 32'h8,  0, 32'h2000_002A, 6'h3F, 6'h00);
        vt[5]  = mk(1, 1, 32'hFC00_003F, 0, 32'h8,  1, 32'hFC00_003F, 6'h3F, 6'h3F);
        vt[6]  = mk(1, 1, 32'h7777_7777, 1, 32'hC,  0, 32'hFC00_003F, 6'h3F, 6'h00);
        // Ack delayed 3 cycles: req/addr stable, pc_enable ignored in REQ.
        vt[7]  = mk(1, 0, 32'hDEAD_BEEF, 1, 32'hC,  0, 32'hFC00_003F, 6'h3F, 6'h00);
        vt[8]  = mk(1, 0, 32'hDEAD_BEEF, 1, 32'hC,  0, 32'hFC00_003F, 6'h3F, 6'h00);
        vt[9]  = mk(1, 0, 32'hDEAD_BEEF, 1, 32'hC,  0, 32'hFC00_003F, 6'h3F, 6'h00);
        vt[10] = mk(1, 1, 32'h0000_0020, 0, 32'hC,  1, 32'h0000_0020, 6'h00, 6'h20);
        // HOLD with no advance for 5 cycles; stray acks without a request are ignored.
        vt[11] = mk(0, 1, 32'h1111_1111, 0, 32'hC,  1, 32'h0000_0020, 6'h00, 6'h20);
        vt[12] = mk(0, 1, 32'h1111_1111, 0, 32'hC,  1, 32'h0000_0020, 6'h00, 6'h20);
        vt[13] = mk(0, 1, 32'h1111_1111, 0, 32'hC,  1, 32'h0000_0020, 6'h00, 6'h20);
        vt[14] = mk(0, 1, 32'h1111_1111, 0, 32'hC,  1, 32'h0000_0020, 6'h00, 6'h20);
        vt[15] = mk(0, 1, 32'h1111_1111, 0, 32'hC,  1, 32'h0000_0020, 6'h00, 6'h20);
        vt[16] = mk(1, 0, 32'h0,         1, 32'h10, 0, 32'h0000_0020, 6'h3F, 6'h00);
        vt[17] = mk(0, 0, 32'h0,         1, 32'h10, 0, 32'h0000_0020, 6'h3F, 6'h00);
        vt[18] = mk(0, 1, 32'h0400_0001, 0, 32'h10, 1, 32'h0400_0001, 6'h01, 6'h01);

        rst = 1; en = 0; ack = 0; data = '0;
        rst2 = 1; en2 = 0; ack2 = 0; data2 = '0;

        // Reset state
        step();
        step();
        chk_main("reset", 0, 32'h0, 0, 32'h0, 6'h3F, 6'h00);
        chk("reset wrap pc", pc2, 32'hFFFF_FFFC);
        rst = 0;

        for (int i = 0; i < NV; i++) begin
            en = vt[i].en; ack = vt[i].ack; data = vt[i].data;
            step();
            chk_main($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].valid,
                     vt[i].instr, vt[i].op, vt[i].fn);
        end

        // PC wrap: one fetch at FFFF_FFFC then advance to 0 with no error.
        rst2 = 0;
        step();
        chk("wrap req", 32'(req2), 32'd1);
        chk("wrap addr0", addr2, 32'hFFFF_FFFC);
        ack2 = 1; data2 = 32'h0000_0025;
        step();
        chk("wrap valid", 32'(valid2), 32'd1);
        chk("wrap func", 32'(fn2), 32'h25);
        ack2 = 0; en2 = 1;
        step();
        chk("wrap pc", pc2, 32'h0);
        chk("wrap addr1", addr2, 32'h0);
        chk("wrap req2", 32'(req2), 32'd1);
        chk("wrap err", 32'(err2), 32'd0);
        chk("wrap instr kept", instr2, 32'h0000_0025);
        en2 = 0;

        // Reset asserted in REQ with an ack in the same cycle.
        en = 1; ack = 0;
        step();
        chk_main("pre-rst", 1, 32'h14, 0, 32'h0400_0001, 6'h3F, 6'h00);
        en = 0; ack = 1; data = 32'h1234_5678; rst = 1;
        #1;
        chk_main("async rst", 0, 32'h0, 0, 32'h0, 6'h3F, 6'h00);
        step();
        chk_main("in rst", 0, 32'h0, 0, 32'h0, 6'h3F, 6'h00);
        rst = 0;
        step();
        chk_main("post rst", 1, 32'h0, 0, 32'h0, 6'h3F, 6'h00);
        ack = 0;

`ifdef FETCH_TIMEOUT_EN
        // Now one edge into REQ; 15 more unanswered edges keep waiting, the 16th trips.
        repeat (15) step();
        chk("to before req", 32'(req), 32'd1);
        chk("to before err", 32'(err), 32'd0);
        step();
        chk("to err", 32'(err), 32'd1);
        chk("to req", 32'(req), 32'd0);
        ack = 1; en = 1; data = 32'h0000_0001;
        repeat (4) step();
        chk("to sticky err", 32'(err), 32'd1);
        chk("to sticky req", 32'(req), 32'd0);
        chk("to valid", 32'(valid), 32'd0);
        chk("to opcode", 32'(op), 32'h3F);
        chk("to pc", pc, 32'h0);
        ack = 0; en = 0;
        rst = 1;
        #1;
        chk("to rst err", 32'(err), 32'd0);
        step();
        rst = 0;
        step();
        chk("to rst req", 32'(req), 32'd1);
`else
        // Without the watchdog REQ waits indefinitely.
        repeat (20) step();
        chk("nowd req", 32'(req), 32'd1);
        chk("nowd err", 32'(err), 32'd0);
        chk("nowd addr", addr, 32'h0);
        chk("nowd valid", 32'(valid), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the opcode/func control decoder.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Holds the fetched instruction in an instruction register and presents opcode/func fields to the decoder.
- Advances to the next instruction only when the decoder asserts pc_enable.

Parameters:
- ADDR_WIDTH, 32: width of the PC and the instruction-memory address.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- PC_STEP, 4: PC increment per advance (byte addressing, word instructions).
- BUBBLE_OPCODE, 6'b111111: opcode driven while no valid instruction is held.
- TIMEOUT_CYCLES, 16: ack watchdog limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clk_in  input  1  single clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- pc_enable_in  input  1  advance request from the control decoder.
- imem_req_out  output  1  fetch request to instruction memory.
- imem_addr_out  output  ADDR_WIDTH  fetch address; always equals pc_out.
- imem_ack_in  input  1  memory ack; imem_data_in is valid in the same cycle.
- imem_data_in  input  32  fetched instruction word.
- instr_out  output  32  instruction register.
- opcode_out  output  6  instr[31:26] when valid, else BUBBLE_OPCODE.
- func_out  output  6  instr[5:0] when valid, else 6'b000000.
- instr_valid_out  output  1  instruction register holds a valid instruction.
- pc_out  output  ADDR_WIDTH  address of the held or pending instruction.
- fetch_error_out  output  1  sticky fetch timeout flag.

Behaviour:
- Reset: one clock (clk_in) and an asynchronous, active-high reset (rst_in).
  - Asserting rst_in immediately clears the state to IDLE.
  - Reset output values: pc_out = RESET_PC, imem_req_out = 0, instr_out = 0, instr_valid_out = 0, fetch_error_out = 0, opcode_out = BUBBLE_OPCODE, func_out = 0.
- Reset mid-fetch: the outstanding request is dropped with no retry memory. An ack that arrives during reset, or while imem_req_out = 0, is ignored.
- FSM states:
  - IDLE: entered from reset. Goes to REQ on the first clock edge after rst_in deasserts.
  - REQ: imem_req_out = 1 (registered), imem_addr_out = pc. While imem_ack_in = 0, stay in REQ; req and addr stay stable. On a clock edge with imem_ack_in = 1: instr <= imem_data_in, instr_valid_out <= 1, imem_req_out <= 0, go to HOLD.
  - HOLD: instr_valid_out = 1.
    - If pc_enable_in = 1: pc <= pc + PC_STEP, instr_valid_out <= 0, go to REQ.
    - If pc_enable_in = 0: hold; instr and pc are unchanged.
    - pc_enable_in is ignored in IDLE and REQ.
- Latency and throughput:
  - The instruction is visible on instr_out the cycle after the ack.
  - With zero-wait-state memory (ack in the first REQ cycle), throughput is one instruction per 2 cycles.
- Arithmetic: the PC increment wraps modulo 2^ADDR_WIDTH. Example: 32'hFFFF_FFFC + 4 gives 32'h0000_0000 with no flag. The PC is never misaligned because RESET_PC is word aligned.
- Field decode: opcode_out and func_out are combinational from the instruction register and instr_valid_out.
- Bubble: while not valid, opcode_out = BUBBLE_OPCODE. This steers the decoder to its default branch (regfile_we = 0, data_mem_we = 0), so no architectural state changes.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without an ack.
  - When the count reaches TIMEOUT_CYCLES: fetch_error_out <= 1, imem_req_out <= 0, go to ERROR.
  - ERROR is left only by reset. In ERROR, opcode_out = BUBBLE_OPCODE and instr_valid_out = 0.
- Undefined: REQ waits indefinitely; fetch_error_out is tied to 0; no counter logic is synthesised.

Test Plan:
- Reset release, ack held high, pc_enable_in = 1 constantly -> imem_addr_out sequence 0x0, 0x4, 0x8, 0xC. instr_valid_out pulses every 2nd cycle.
- Ack delayed 3 cycles, imem_data_in = 32'h0000_0020 -> req and addr held stable for 3 cycles. Then instr_out = 32'h0000_0020, opcode_out = 0x00, func_out = 0x20.
- In HOLD, pc_enable_in = 0 for 5 cycles -> instr_out and pc_out unchanged, imem_req_out = 0. pc_enable_in = 1 -> pc_out + 4 and new request next cycle.
- RESET_PC = 32'hFFFF_FFFC, one fetch then advance -> pc_out = 32'h0000_0000, no error.
- Assert rst_in while in REQ with an ack arriving in the same cycle -> req drops asynchronously, ack ignored, pc_out = RESET_PC, opcode_out = 6'b111111.
- FETCH_TIMEOUT_EN defined, no ack -> fetch_error_out = 1 after 16 REQ cycles, req = 0. Stays in that state until reset.
